coin_arbiter: RTL and testbench

//  Sequences the 8-bit Fibonacci coin LFSR (taps 8,6,5,4; shifts one bit per enabled cycle) and shares its output

---
 rtl/coin_arbiter.sv | 163 ++++++++++++++++
 tb/tb_coin_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coin_arbiter.sv
// Sequences an external 8-bit Fibonacci coin LFSR and delivers BYTES-byte words to two round-robin requesters.
// Define COIN_ARB_WARMUP_EN to discard WARMUP LFSR shifts after every seed load.
module coin_arbiter #(
    parameter int BYTES  = 4,
    parameter int WARMUP = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               seed_ld,
    input  logic [7:0]         seed,
    output logic               lfsr_ld,
    output logic [7:0]         lfsr_seed,
    output logic               lfsr_en,
    input  logic [7:0]         lfsr_q,
    input  logic [1:0]         req,
    output logic [1:0]         gnt,
    output logic               coin_valid,
    input  logic               coin_ready,
    output logic [8*BYTES-1:0] coin_data
);

    localparam int BCW = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {
        S_UNSEEDED = 3'd0,
        S_LOAD     = 3'd1,
        S_IDLE     = 3'd2,
        S_FILL     = 3'd3,
        S_OFFER    = 3'd4
`ifdef COIN_ARB_WARMUP_EN
        , S_WARM   = 3'd5
`endif
    } state_t;

    state_t             state_q;
    logic               lfsr_ld_q;
    logic [7:0]         lfsr_seed_q;
    logic               lfsr_en_q;
    logic [1:0]         gnt_q;
    logic               coin_valid_q;
    logic [8*BYTES-1:0] coin_data_q;
    logic               rr_ptr_q;
    logic [2:0]         bit_cnt_q;
    logic [BCW-1:0]     byte_cnt_q;
    logic [7:0]         lfsr_next_d;
    logic [1:0]         gnt_d;

`ifdef COIN_ARB_WARMUP_EN
    localparam int WCW = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    logic [WCW-1:0]     warm_cnt_q;
`endif

    // Out-of-range parameters elaborate an undriven flag so lint and synthesis reports surface them.
    if (BYTES < 1 || BYTES > 16 || WARMUP < 0) begin : g_param_range_error
        logic param_range_error;
    end

    // The byte is captured on the same edge as the 8th shift, so take the post-shift value directly.
    assign lfsr_next_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_comb begin
        gnt_d = req;
        if (req == 2'b11) begin
            gnt_d = rr_ptr_q ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_UNSEEDED;
            lfsr_ld_q    <= 1'b0;
            lfsr_seed_q  <= 8'h00;
            lfsr_en_q    <= 1'b0;
            gnt_q        <= 2'b00;
            coin_valid_q <= 1'b0;
            coin_data_q  <= '0;
            rr_ptr_q     <= 1'b0;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= '0;
`ifdef COIN_ARB_WARMUP_EN
            warm_cnt_q   <= '0;
`endif
        end else if (seed_ld) begin
            state_q      <= S_LOAD;
            lfsr_ld_q    <= 1'b1;
            lfsr_seed_q  <= (seed == 8'h00) ? 8'hFF : seed;
            lfsr_en_q    <= 1'b0;
            gnt_q        <= 2'b00;
            coin_valid_q <= 1'b0;
            coin_data_q  <= '0;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= '0;
        end else begin
            lfsr_ld_q <= 1'b0;
            case (state_q)
                S_UNSEEDED: begin
                end
                S_LOAD: begin
`ifdef COIN_ARB_WARMUP_EN
                    if (WARMUP > 0) begin
                        state_q    <= S_WARM;
                        lfsr_en_q  <= 1'b1;
                        warm_cnt_q <= '0;
                    end else begin
                        state_q    <= S_IDLE;
                    end
`else
                    state_q <= S_IDLE;
`endif
                end
`ifdef COIN_ARB_WARMUP_EN
                S_WARM: begin
                    if (warm_cnt_q == WCW'(WARMUP - 1)) begin
                        state_q   <= S_IDLE;
                        lfsr_en_q <= 1'b0;
                    end else begin
                        warm_cnt_q <= warm_cnt_q + 1'b1;
                    end
                end
`endif
                S_IDLE: begin
                    if (gnt_d != 2'b00) begin
                        state_q    <= S_FILL;
                        gnt_q      <= gnt_d;
                        lfsr_en_q  <= 1'b1;
                        bit_cnt_q  <= 3'd0;
                        byte_cnt_q <= '0;
                    end
                end
                S_FILL: begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        coin_data_q[{byte_cnt_q, 3'b000} +: 8] <= lfsr_next_d;
                        if (byte_cnt_q == BCW'(BYTES - 1)) begin
                            state_q      <= S_OFFER;
                            lfsr_en_q    <= 1'b0;
                            coin_valid_q <= 1'b1;
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                        end
                    end
                end
                S_OFFER: begin
                    if (coin_ready) begin
                        state_q      <= S_IDLE;
                        coin_valid_q <= 1'b0;
                        gnt_q        <= 2'b00;
                        rr_ptr_q     <= gnt_q[1];
                    end
                end
                default: state_q <= S_UNSEEDED;
            endcase
        end
    end

    assign lfsr_ld    = lfsr_ld_q;
    assign lfsr_seed  = lfsr_seed_q;
    assign lfsr_en    = lfsr_en_q;
    assign gnt        = gnt_q;
    assign coin_valid = coin_valid_q;
    assign coin_data  = coin_data_q;

endmodule

// File: tb/tb_coin_arbiter.sv
// Scoreboard bench for coin_arbiter: stimulus pushes expected {gnt, word} entries, a negedge monitor pops them on handshakes.
module tb_coin_arbiter;

`ifdef COIN_ARB_WARMUP_EN
    localparam int WU = 64;
`else
    localparam int WU = 0;
`endif
    // Hand-computed word from seed 0xFF: bytes after 8/16/24/32 shifts are 0B, C6, 80, 8E.
    localparam logic [31:0] WORD_FF = 32'h8E80C60B;

    typedef struct packed {
        logic [1:0]  g;
        logic [31:0] d;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_ld = 1'b0;
    logic [7:0]  seed = 8'h00;
    logic        lfsr_ld;
    logic [7:0]  lfsr_seed;
    logic        lfsr_en;
    logic [7:0]  lfsr_state = 8'h00;
    logic [1:0]  req = 2'b00;
    logic [1:0]  gnt;
    logic        coin_valid;
    logic        coin_ready = 1'b0;
    logic [31:0] coin_data;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          hs_count = 0;
    logic [7:0]  model_lfsr = 8'h00;
    logic        last_served = 1'b0;

    coin_arbiter #(.BYTES(4), .WARMUP(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_ld    (seed_ld),
        .seed       (seed),
        .lfsr_ld    (lfsr_ld),
        .lfsr_seed  (lfsr_seed),
        .lfsr_en    (lfsr_en),
        .lfsr_q     (lfsr_state),
        .req        (req),
        .gnt        (gnt),
        .coin_valid (coin_valid),
        .coin_ready (coin_ready),
        .coin_data  (coin_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // External LFSR the arbiter drives
    always @(posedge clk) begin
        if (lfsr_ld)      lfsr_state <= lfsr_seed;
        else if (lfsr_en) lfsr_state <= lfsr_step(lfsr_state);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (lfsr_ld) begin
                checks++;
                if (lfsr_en) begin
                    errors++;
                    $display("FAIL ld_en_exclusive: lfsr_en=%b while lfsr_ld=1, required 0", lfsr_en);
                end
            end
            if (coin_valid && coin_ready && !seed_ld) begin
                hs_count++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL word_unexpected: got gnt=%b data=%h, required no word", gnt, coin_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({gnt, coin_data} !== {mon_e.g, mon_e.d}) begin
                        errors++;
                        $display("FAIL word: got gnt=%b data=%h, required gnt=%b data=%h",
                                 gnt, coin_data, mon_e.g, mon_e.d);
                    end else begin
                        $display("word ok: gnt=%b data=%h", gnt, coin_data);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req_v);
        end
    endtask

    task automatic push_word(input logic [1:0] g, input bit use_const);
        exp_t e;
        e.g = g;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) model_lfsr = lfsr_step(model_lfsr);
            e.d[b*8 +: 8] = model_lfsr;
        end
        if (use_const && WU == 0) e.d = WORD_FF;
        exp_q.push_back(e);
    endtask

    task automatic do_seed(input logic [7:0] s);
        logic [7:0] eff;
        int         en_cnt;
        eff = (s == 8'h00) ? 8'hFF : s;
        seed = s;
        seed_ld = 1'b1;
        tick();
        seed_ld = 1'b0;
        coin_ready = 1'b0;
        chk("load_strobe", {63'd0, lfsr_ld}, 64'd1);
        chk("load_seed", {56'd0, lfsr_seed}, {56'd0, eff});
        chk("load_gnt_valid", {61'd0, gnt, coin_valid}, 64'd0);
        model_lfsr = eff;
        en_cnt = 0;
        for (int c = 0; c < WU + 4; c++) begin
            tick();
            if (lfsr_en) en_cnt++;
            if (c == 0) chk("load_strobe_drop", {63'd0, lfsr_ld}, 64'd0);
        end
        chk("warm_shifts", en_cnt, WU);
        for (int i = 0; i < WU; i++) model_lfsr = lfsr_step(model_lfsr);
        $display("seeded: seed=%h effective=%h warm_shifts=%0d", s, eff, en_cnt);
    endtask

    task automatic run_words(input logic [1:0] r, input int n, input bit use_const);
        logic [1:0] g;
        int         target;
        for (int w = 0; w < n; w++) begin
            g = (r == 2'b11) ? (last_served ? 2'b01 : 2'b10) : r;
            last_served = g[1];
            push_word(g, use_const);
        end
        target = hs_count + n;
        req = r;
        coin_ready = 1'b1;
        for (int c = 0; c < 40*n + 20 && hs_count < target; c++) tick();
        chk("handshake_count", hs_count, target);
        req = 2'b00;
        coin_ready = 1'b0;
        tick();
        chk("post_word_idle", {61'd0, gnt, coin_valid}, 64'd0);
    endtask

    initial begin
        int lat;
        int en_cnt;
        int hs_before;

        // Reset state
        tick(); tick();
        chk("rst_lfsr_ld", {63'd0, lfsr_ld}, 64'd0);
        chk("rst_lfsr_seed", {56'd0, lfsr_seed}, 64'd0);
        chk("rst_lfsr_en", {63'd0, lfsr_en}, 64'd0);
        chk("rst_gnt", {62'd0, gnt}, 64'd0);
        chk("rst_valid", {63'd0, coin_valid}, 64'd0);
        chk("rst_data", {32'd0, coin_data}, 64'd0);
        rst = 1'b0;

        // Requests ignored while unseeded
        req = 2'b11;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("unseeded_gnt", {61'd0, gnt, coin_valid}, 64'd0);
        end
        req = 2'b00;

        // Seed 0xFF, single requester, latency and stall in OFFER
        do_seed(8'hFF);
        push_word(2'b01, 1'b1);
        last_served = 1'b0;
        req = 2'b01;
        tick();
        chk("t1_gnt_at_fill", {62'd0, gnt}, 64'd1);
        en_cnt = lfsr_en ? 1 : 0;
        lat = 1;
        while (!coin_valid && lat < 100) begin
            tick();
            lat++;
            if (lfsr_en) en_cnt++;
        end
        chk("t1_latency", lat, 33);
        chk("t1_fill_shifts", en_cnt, 32);
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("stall_data", {32'd0, coin_data}, {32'd0, exp_q[0].d});
            chk("stall_gnt_en_valid", {60'd0, gnt, lfsr_en, coin_valid}, {60'd0, 2'b01, 1'b0, 1'b1});
        end
        hs_before = hs_count;
        coin_ready = 1'b1;
        tick();
        coin_ready = 1'b0;
        req = 2'b00;
        chk("t1_handshake", hs_count, hs_before + 1);
        chk("t1_release", {61'd0, gnt, coin_valid}, 64'd0);
        tick();

        // Both requesting: alternate grants for six words
        run_words(2'b11, 6, 1'b0);

        // Zero seed replaced by 0xFF
        do_seed(8'h00);
        run_words(2'b01, 1, 1'b1);

        // Reseed mid-FILL at byte 2 discards the partial word
        do_seed(8'hFF);
        req = 2'b01;
        for (int c = 0; c < 20; c++) tick();
        chk("t4_no_valid_in_fill", {63'd0, coin_valid}, 64'd0);
        req = 2'b00;
        do_seed(8'h3C);
        run_words(2'b01, 1, 1'b0);

        // Warm-up seed (model accounts for warm-up when compiled in)
        do_seed(8'hA5);
        run_words(2'b01, 1, 1'b0);

        // Single request from requester 1, then seed_ld racing coin_ready in OFFER
        run_words(2'b10, 1, 1'b0);
        req = 2'b01;
        lat = 0;
        while (!coin_valid && lat < 100) begin
            tick();
            lat++;
        end
        chk("t9_offer_reached", {63'd0, coin_valid}, 64'd1);
        hs_before = hs_count;
        req = 2'b00;
        coin_ready = 1'b1;
        do_seed(8'h5A);
        chk("t9_handshake_not_counted", hs_count, hs_before);
        run_words(2'b11, 1, 1'b0);

        // Async reset mid-FILL, then rr pointer back to 0
        req = 2'b01;
        for (int c = 0; c < 10; c++) tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outputs", {25'd0, lfsr_ld, lfsr_en, gnt, coin_valid, lfsr_seed, coin_data},
            64'd0);
        tick();
        rst = 1'b0;
        last_served = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("post_rst_unseeded", {61'd0, gnt, coin_valid}, 64'd0);
        end
        req = 2'b00;
        do_seed(8'h5A);
        run_words(2'b11, 1, 1'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
